// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-master memory arbiter: state encoding,
// master IDs and default parameter values.
package mem_arb_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_M0    = 3'd1;
    localparam logic [2:0] ST_M1    = 3'd2;
    localparam logic [2:0] ST_LOCK0 = 3'd3;
    localparam logic [2:0] ST_LOCK1 = 3'd4;

    // Last-owner record; the LOCK states exist only with MEM_ARB_LOCK_EN.
    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_M0    = ST_M0,
        S_M1    = ST_M1,
        S_LOCK0 = ST_LOCK0,
        S_LOCK1 = ST_LOCK1
    } arb_state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int STARVE_LIMIT_DEF = 4;
    localparam int LOCK_MAX_DEF     = 8;
    localparam int DATA_W_DEF       = 32;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating up-counter with synchronous clear; flags when it sits at LIMIT.
// Used for the m1 anti-starvation count and, with locking, the lock-hold count.
module arb_starve_ctr #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_limit_o
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q;

    // Clear has priority over increment; counting stops at LIMIT.
    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && !at_limit_o) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign at_limit_o = (cnt_q == W'(LIMIT));

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the unified instruction/data memory.
// m0 (CPU) has fixed priority; m1 is forced ahead after STARVE_LIMIT refusals.
// Optional atomic locking is compiled in when MEM_ARB_LOCK_EN is defined.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int LOCK_MAX     = LOCK_MAX_DEF,
    parameter int DATA_W       = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [DATA_W-1:0] m0_adr,
    input  logic [DATA_W-1:0] m0_wd,
    input  logic              m0_lock,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [DATA_W-1:0] m1_adr,
    input  logic [DATA_W-1:0] m1_wd,
    input  logic              m1_lock,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rd
);

    arb_state_e        state_q, state_d;
    logic              gnt0, gnt1, sel;
    logic              starve_at_limit;
    logic              rvalid0_q, rvalid1_q;
    logic [DATA_W-1:0] rdata_q;

    arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk        (clk),
        .reset      (reset),
        .inc_i      (m1_req && !gnt1),
        .clr_i      (!m1_req || gnt1),
        .at_limit_o (starve_at_limit)
    );

`ifdef MEM_ARB_LOCK_EN
    logic lock_at_limit, lock_inc, force_rel, hold_lock;

    arb_starve_ctr #(.LIMIT(LOCK_MAX)) u_lock (
        .clk        (clk),
        .reset      (reset),
        .inc_i      (lock_inc),
        .clr_i      (!lock_inc),
        .at_limit_o (lock_at_limit)
    );
`else
    logic unused_lock;
    localparam int UNUSED_LOCK_MAX = LOCK_MAX;
    assign unused_lock = ^{m0_lock, m1_lock, state_q, UNUSED_LOCK_MAX[0]};
`endif

    // Grant selection and next owner state, all from current req/state/counters.
    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        state_d = S_IDLE;
        if (m0_req && m1_req) begin
            if (starve_at_limit) gnt1 = 1'b1;
            else                 gnt0 = 1'b1;
        end else if (m0_req) begin
            gnt0 = 1'b1;
        end else if (m1_req) begin
            gnt1 = 1'b1;
        end
`ifdef MEM_ARB_LOCK_EN
        lock_inc  = 1'b0;
        force_rel = 1'b0;
        hold_lock = 1'b0;
        if (state_q == S_LOCK0 && m0_lock) begin
            if (lock_at_limit) begin
                // Forced release: the waiting master goes first.
                force_rel = 1'b1;
                gnt1      = m1_req;
                gnt0      = m0_req && !m1_req;
            end else begin
                lock_inc  = 1'b1;
                hold_lock = 1'b1;
                gnt0      = m0_req;
                gnt1      = 1'b0;
            end
        end else if (state_q == S_LOCK1 && m1_lock) begin
            if (lock_at_limit) begin
                force_rel = 1'b1;
                gnt0      = m0_req;
                gnt1      = m1_req && !m0_req;
            end else begin
                lock_inc  = 1'b1;
                hold_lock = 1'b1;
                gnt1      = m1_req;
                gnt0      = 1'b0;
            end
        end
        if (reset) begin
            lock_inc = 1'b0;
        end
`endif
        // No access is performed while reset is held.
        if (reset) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
`ifdef MEM_ARB_LOCK_EN
        if (gnt0)           state_d = (m0_lock && !force_rel) ? S_LOCK0 : S_M0;
        else if (gnt1)      state_d = (m1_lock && !force_rel) ? S_LOCK1 : S_M1;
        else if (hold_lock) state_d = state_q;
`else
        if (gnt0)      state_d = S_M0;
        else if (gnt1) state_d = S_M1;
`endif
    end

    // Owner state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Read data capture and per-master valid strobe, one cycle after a read grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q   <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            rvalid0_q <= gnt0 && !m0_we;
            rvalid1_q <= gnt1 && !m1_we;
            if ((gnt0 && !m0_we) || (gnt1 && !m1_we)) rdata_q <= mem_rd;
        end
    end

    assign sel       = gnt1 ? M1 : M0;
    assign mem_adr   = !(gnt0 || gnt1) ? '0 : (sel == M1) ? m1_adr : m0_adr;
    assign mem_wd    = !(gnt0 || gnt1) ? '0 : (sel == M1) ? m1_wd : m0_wd;
    assign mem_we    = (gnt0 && m0_we) || (gnt1 && m1_we);
    assign m0_gnt    = gnt0;
    assign m1_gnt    = gnt1;
    assign m0_rvalid = rvalid0_q && !reset;
    assign m1_rvalid = rvalid1_q && !reset;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (STARVE_LIMIT=4, LOCK_MAX=8).
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
    logic        m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
    logic [31:0] m0_adr, m0_wd, m1_adr, m1_wd;
    logic [31:0] rdata, mem_adr, mem_wd, mem_rd;
    logic        mem_we;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(4), .LOCK_MAX(8), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_adr    (m0_adr),
        .m0_wd     (m0_wd),
        .m0_lock   (m0_lock),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_adr    (m1_adr),
        .m1_wd     (m1_wd),
        .m1_lock   (m1_lock),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .rdata     (rdata),
        .mem_adr   (mem_adr),
        .mem_wd    (mem_wd),
        .mem_we    (mem_we),
        .mem_rd    (mem_rd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        m0_req = 1'b1; m0_we = 1'b0; m0_adr = '0; m0_wd = '0; m0_lock = 1'b0;
        m1_req = 1'b1; m1_we = 1'b0; m1_adr = '0; m1_wd = '0; m1_lock = 1'b0;
        mem_rd = 32'h5555_AAAA;

        // Reset held two cycles with both requests high
        tick();
        chk("rst_m0_gnt", 32'(m0_gnt), 32'd0);
        chk("rst_m1_gnt", 32'(m1_gnt), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        tick();
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
        chk("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
        chk("rst_mem_adr", mem_adr, 32'h0);
        reset = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
        #1;
        chk("idle_m0_gnt", 32'(m0_gnt), 32'd0);
        chk("idle_mem_wd", mem_wd, 32'h0);
        tick();

        // Single m0 read
        m0_req = 1'b1; m0_we = 1'b0; m0_adr = 32'h40; mem_rd = 32'hDEADBEEF;
        #1;
        chk("rd_m0_gnt", 32'(m0_gnt), 32'd1);
        chk("rd_m1_gnt", 32'(m1_gnt), 32'd0);
        chk("rd_mem_adr", mem_adr, 32'h40);
        chk("rd_mem_we", 32'(mem_we), 32'd0);
        tick();
        m0_req = 1'b0; mem_rd = 32'h0;
        #1;
        chk("rd_m0_rvalid", 32'(m0_rvalid), 32'd1);
        chk("rd_m1_rvalid", 32'(m1_rvalid), 32'd0);
        chk("rd_rdata", rdata, 32'hDEADBEEF);
        chk("rd_idle_adr", mem_adr, 32'h0);
        tick();
        chk("rd_rvalid_one", 32'(m0_rvalid), 32'd0);
        chk("rd_rdata_hold", rdata, 32'hDEADBEEF);

        // Contention: four m0 grants then one forced m1 grant, repeating
        m0_req = 1'b1; m1_req = 1'b1; m0_adr = 32'h200; m1_adr = 32'h300;
        for (int i = 0; i < 10; i++) begin
            mem_rd = 32'h1000 + 32'(i);
            #1;
            chk("cont_m0_gnt", 32'(m0_gnt), 32'((i % 5) != 4));
            chk("cont_m1_gnt", 32'(m1_gnt), 32'((i % 5) == 4));
            chk("cont_mem_adr", mem_adr, ((i % 5) == 4) ? 32'h300 : 32'h200);
            if (i > 0) begin
                chk("cont_rdata", rdata, 32'h1000 + 32'(i - 1));
                chk("cont_m1_rvalid", 32'(m1_rvalid), 32'(i == 5));
            end
            tick();
        end
        m0_req = 1'b0; m1_req = 1'b0;
        tick();

        // m1 write with m0 idle
        m1_req = 1'b1; m1_we = 1'b1; m1_adr = 32'h100; m1_wd = 32'h12345678;
        #1;
        chk("wr_m1_gnt", 32'(m1_gnt), 32'd1);
        chk("wr_mem_we", 32'(mem_we), 32'd1);
        chk("wr_mem_wd", mem_wd, 32'h12345678);
        chk("wr_mem_adr", mem_adr, 32'h100);
        tick();
        m1_req = 1'b0; m1_we = 1'b0;
        #1;
        chk("wr_mem_we_off", 32'(mem_we), 32'd0);
        chk("wr_no_rvalid", 32'(m1_rvalid), 32'd0);
        chk("wr_rdata_hold", rdata, 32'h1009);
        chk("wr_mem_wd_idle", mem_wd, 32'h0);
        tick();

`ifdef MEM_ARB_LOCK_EN
        // m1 takes a lock; m0 is refused until the forced release after 8 locked cycles
        m1_req = 1'b1; m1_lock = 1'b1; m1_adr = 32'h500;
        #1;
        chk("lk_enter_m1_gnt", 32'(m1_gnt), 32'd1);
        tick();
        m0_req = 1'b1; m0_adr = 32'h600;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("lk_hold_m1_gnt", 32'(m1_gnt), 32'd1);
            chk("lk_hold_m0_gnt", 32'(m0_gnt), 32'd0);
            tick();
        end
        #1;
        chk("lk_rel_m0_gnt", 32'(m0_gnt), 32'd1);
        chk("lk_rel_m1_gnt", 32'(m1_gnt), 32'd0);
        m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;
        tick();
`else
        // Lock inputs have no effect: m0 still wins a tie with m1 holding lock
        m0_req = 1'b1; m1_req = 1'b1; m1_lock = 1'b1; m0_lock = 1'b1;
        #1;
        chk("nolk_m0_gnt", 32'(m0_gnt), 32'd1);
        chk("nolk_m1_gnt", 32'(m1_gnt), 32'd0);
        m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0; m0_lock = 1'b0;
        tick();
`endif

        // Reset arrives in the cycle after a read grant
        m0_req = 1'b1; m0_we = 1'b0; m0_adr = 32'h80; mem_rd = 32'hCAFEF00D;
        #1;
        chk("rr_m0_gnt", 32'(m0_gnt), 32'd1);
        tick();
        reset = 1'b1; m0_req = 1'b0;
        #1;
        chk("rr_rvalid_supp", 32'(m0_rvalid), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("rr_rdata", rdata, 32'h0);
        chk("rr_m0_rvalid", 32'(m0_rvalid), 32'd0);
        chk("rr_m0_gnt", 32'(m0_gnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
